// File: rtl/second_tick_if.sv
// Timebase bundle: control inputs into the second tick generator and its registered outputs.
// master is the generator side; slave is the consumer side.
interface second_tick_if;
    logic       enable;
    logic       sync_clear;
    logic       one_second_clk;
    logic       tick;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic       min_wrap;

    modport master (
        input  enable,
        input  sync_clear,
        output one_second_clk,
        output tick,
        output seconds,
        output minutes,
        output min_wrap
    );

    modport slave (
        output enable,
        output sync_clear,
        input  one_second_clk,
        input  tick,
        input  seconds,
        input  minutes,
        input  min_wrap
    );
endinterface

// File: rtl/second_tick_gen.sv
// Divides clk into a TICK_HZ square wave, with a tick pulse on each rising edge and a
// seconds/minutes wall-time count. All outputs are registered.
module second_tick_gen #(
    parameter int unsigned CLK_HZ  = 27000000,
    parameter int unsigned TICK_HZ = 1
) (
    input logic            clk,
    input logic            rst,
    second_tick_if.master  bus
);
    localparam int unsigned HALF = CLK_HZ / (2 * TICK_HZ);
    localparam int unsigned CW   = (HALF < 2) ? 1 : $clog2(HALF);
    localparam logic [CW-1:0] CntMax = CW'(HALF - 1);

    if (HALF < 2) begin : g_bad_half
        $error("second_tick_gen: CLK_HZ/(2*TICK_HZ) must be at least 2");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wave_q, wave_d;
    logic          tick_q, tick_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic          wrap_q, wrap_d;

    always_comb begin
        cnt_d  = cnt_q;
        wave_d = wave_q;
        sec_d  = sec_q;
        min_d  = min_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        if (bus.sync_clear) begin
            cnt_d  = '0;
            wave_d = 1'b0;
            sec_d  = '0;
            min_d  = '0;
        end else if (bus.enable) begin
            if (cnt_q == CntMax) begin
                cnt_d  = '0;
                wave_d = ~wave_q;
                // Time only advances on the rising edge of the wave.
                if (!wave_q) begin
                    tick_d = 1'b1;
                    if (sec_q == 6'd59) begin
                        sec_d = '0;
                        if (min_q == 6'd59) begin
                            min_d  = '0;
                            wrap_d = 1'b1;
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
            tick_q <= 1'b0;
            sec_q  <= '0;
            min_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
            tick_q <= tick_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.one_second_clk = wave_q;
    assign bus.tick           = tick_q;
    assign bus.seconds        = sec_q;
    assign bus.minutes        = min_q;
    assign bus.min_wrap       = wrap_q;
endmodule

// File: tb/tb_second_tick_gen.sv
// Directed bench for second_tick_gen at CLK_HZ=8, TICK_HZ=1 (four cycles per half-period).
module tb_second_tick_gen;
    localparam int unsigned HALF = 4;

    logic clk = 1'b0;
    logic rst;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    second_tick_if bus ();

    second_tick_gen #(
        .CLK_HZ  (8),
        .TICK_HZ (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        bus.sync_clear = 1'b1;
        step();
        bus.sync_clear = 1'b0;
    endtask

    task automatic wait_tick();
        bit found = 1'b0;
        for (int i = 0; i < 2 * HALF + 1; i++) begin
            step();
            if (bus.tick) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check_eq("tick_timeout", 0, 1);
    endtask

    initial begin
        rst            = 1'b1;
        bus.enable     = 1'b0;
        bus.sync_clear = 1'b0;
        step();
        step();
        check_eq("rst_wave", bus.one_second_clk, 0);
        check_eq("rst_tick", bus.tick, 0);
        check_eq("rst_sec",  bus.seconds, 0);
        check_eq("rst_min",  bus.minutes, 0);
        check_eq("rst_wrap", bus.min_wrap, 0);

        // Free run from reset release: rise at 4, fall at 8, rise at 12, ...
        rst        = 1'b0;
        bus.enable = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            step();
            check_eq($sformatf("run_tick_c%0d", c), bus.tick, (c % 8 == 4) ? 1 : 0);
            check_eq($sformatf("run_wave_c%0d", c), bus.one_second_clk, ((c / 4) % 2 == 1) ? 1 : 0);
            check_eq($sformatf("run_sec_c%0d", c), bus.seconds, (c + 4) / 8);
        end
        step();
        check_eq("tick_one_cycle", bus.tick, 0);

        // Seconds wrap into minutes on the 60th tick.
        do_clear();
        for (int i = 0; i < 59; i++) wait_tick();
        check_eq("t59_sec", bus.seconds, 59);
        check_eq("t59_min", bus.minutes, 0);
        wait_tick();
        check_eq("t60_sec", bus.seconds, 0);
        check_eq("t60_min", bus.minutes, 1);
        check_eq("t60_wrap", bus.min_wrap, 0);

        // Minutes wrap after 3600 ticks.
        do_clear();
        for (int i = 0; i < 3599; i++) wait_tick();
        check_eq("t3599_sec", bus.seconds, 59);
        check_eq("t3599_min", bus.minutes, 59);
        check_eq("t3599_wrap", bus.min_wrap, 0);
        wait_tick();
        check_eq("t3600_tick", bus.tick, 1);
        check_eq("t3600_sec", bus.seconds, 0);
        check_eq("t3600_min", bus.minutes, 0);
        check_eq("t3600_wrap", bus.min_wrap, 1);
        step();
        check_eq("wrap_one_cycle", bus.min_wrap, 0);
        check_eq("wrap_tick_low", bus.tick, 0);

        // Freeze at count=2 for five cycles; rise comes two enabled cycles after resume.
        do_clear();
        step();
        step();
        bus.enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("frz_wave", bus.one_second_clk, 0);
            check_eq("frz_tick", bus.tick, 0);
            check_eq("frz_sec", bus.seconds, 0);
        end
        bus.enable = 1'b1;
        step();
        check_eq("resume1_wave", bus.one_second_clk, 0);
        check_eq("resume1_tick", bus.tick, 0);
        step();
        check_eq("resume2_wave", bus.one_second_clk, 1);
        check_eq("resume2_tick", bus.tick, 1);
        check_eq("resume2_sec", bus.seconds, 1);

        // Clear on the edge that would have produced a rising wave.
        do_clear();
        for (int i = 0; i < 3; i++) wait_tick();
        for (int i = 0; i < 7; i++) step();
        check_eq("preclr_wave", bus.one_second_clk, 0);
        check_eq("preclr_sec", bus.seconds, 3);
        bus.sync_clear = 1'b1;
        step();
        bus.sync_clear = 1'b0;
        check_eq("clr_tick", bus.tick, 0);
        check_eq("clr_wave", bus.one_second_clk, 0);
        check_eq("clr_sec", bus.seconds, 0);
        check_eq("clr_min", bus.minutes, 0);
        for (int i = 0; i < 3; i++) step();
        check_eq("clr_c3_tick", bus.tick, 0);
        step();
        check_eq("clr_c4_tick", bus.tick, 1);
        check_eq("clr_c4_sec", bus.seconds, 1);

        // Clear wins even with enable low.
        wait_tick();
        bus.enable     = 1'b0;
        bus.sync_clear = 1'b1;
        step();
        bus.sync_clear = 1'b0;
        check_eq("clr_dis_wave", bus.one_second_clk, 0);
        check_eq("clr_dis_sec", bus.seconds, 0);
        bus.enable = 1'b1;

        // Reset mid-high-phase with seconds at 37.
        do_clear();
        for (int i = 0; i < 37; i++) wait_tick();
        step();
        check_eq("prerst_wave", bus.one_second_clk, 1);
        check_eq("prerst_sec", bus.seconds, 37);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rst2_wave", bus.one_second_clk, 0);
        check_eq("rst2_tick", bus.tick, 0);
        check_eq("rst2_sec", bus.seconds, 0);
        check_eq("rst2_min", bus.minutes, 0);
        for (int i = 0; i < 3; i++) step();
        check_eq("rst2_c3_tick", bus.tick, 0);
        step();
        check_eq("rst2_c4_tick", bus.tick, 1);
        check_eq("rst2_c4_wave", bus.one_second_clk, 1);
        check_eq("rst2_c4_sec", bus.seconds, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/second_tick_gen.md
Name: second_tick_gen

Overview:
- Timebase generator that produces the oneSecondClk square wave consumed by the parallel LED controller, from the 27 MHz board clock.
- Also provides a one-cycle tick pulse and a seconds/minutes count (0–59 each) for other consumers that need wall time.
- Sits directly upstream of the LED controller. All outputs are registered in the clk domain.

Parameters:
- CLK_HZ, 27000000, input clock frequency in Hz.
- TICK_HZ, 1, frequency of the one_second_clk square wave in Hz.
- HALF (derived, not overridable), CLK_HZ/(2*TICK_HZ), number of clk cycles per half-period. Must be ≥ 2; elaboration fails otherwise.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous reset, active-high.
- enable, in, 1, count enable. When low, the whole timebase freezes.
- sync_clear, in, 1, synchronous clear of the prescaler, wave and time counters.
- one_second_clk, out, 1, 50% duty square wave at TICK_HZ.
- tick, out, 1, one-cycle pulse on each rising edge of one_second_clk.
- seconds, out, 6, seconds count, 0..59.
- minutes, out, 6, minutes count, 0..59.
- min_wrap, out, 1, one-cycle pulse when minutes wraps from 59 to 0.

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: prescaler count = 0, one_second_clk = 0, tick = 0, seconds = 0, minutes = 0, min_wrap = 0.
- Prescaler:
  - Counter width is $clog2(HALF); it counts 0..HALF-1.
  - On an enabled edge with count == HALF-1: count goes to 0 and one_second_clk toggles.
  - On any other enabled edge: count increments.
- Rising edge of the wave: on the edge where one_second_clk goes 0→1, the same edge also does all of the following, all visible together in the following cycle:
  - sets tick = 1;
  - increments seconds;
  - if seconds was 59: seconds becomes 0 and minutes increments;
  - if minutes was also 59: minutes becomes 0 and min_wrap = 1.
- tick and min_wrap are 0 on every other edge. They are never high for two consecutive cycles.
- Falling edge of the wave (1→0): no tick, counters unchanged.
- Period and latency: one_second_clk period = 2*HALF enabled cycles.
  - After reset (or clear) with enable held high, the first rising edge follows the HALF-th enabled edge, i.e. one_second_clk = 1 and tick = 1 in cycle HALF after the clear.
- enable = 0:
  - count, one_second_clk, seconds and minutes hold their values;
  - tick and min_wrap are forced to 0.
  - When enable returns, counting resumes from the held count with no phase loss.
- sync_clear = 1: next state equals the reset state regardless of enable.
- Priority: rst > sync_clear > enable/count. A clear on the same edge as a pending wrap wins; no tick is emitted.
- Reset or clear mid-period: the phase restarts. one_second_clk is forced low even if it was high; this shortened high phase is acceptable to the consumer.
- Counters never exceed 59. Values 60..63 are unreachable from reset.

Test Plan (CLK_HZ=8, TICK_HZ=1, so HALF=4, unless stated):
- Reset release, enable=1 → one_second_clk rises and tick=1 in cycle 4, falls in cycle 8, rises again in cycle 12. tick is high exactly in cycles 4, 12, 20…; seconds reads 1, 2, 3 after each tick.
- Run 60 ticks → seconds goes 59→0 and minutes goes 0→1 on the 60th tick. Run 3600 ticks → minutes goes 59→0, min_wrap=1 for exactly one cycle, coincident with tick.
- Drop enable for 5 cycles at count=2 → all outputs hold, tick=0. After re-enable, the next toggle occurs 2 enabled cycles later.
- Assert sync_clear in the same cycle as count=3 with one_second_clk=0 → no tick. Next cycle: count=0, one_second_clk=0, seconds=0, minutes=0.
- Assert rst while one_second_clk=1 and seconds=37 → all outputs 0 next cycle. After release, the first tick is in cycle 4.
- Default parameters (27 MHz) → one_second_clk half-period is exactly 13,500,000 cycles; tick spacing is 27,000,000 cycles.
